// File: rtl/cfg_loader_if.sv
// Bitstream/config bus between a host (or upstream tile) and cfg_loader.
// Optional CFG_PARITY_EN adds the cfg_in_parity input.
interface cfg_loader_if #(
  parameter int CFG_SIZE   = 256,
  parameter int WORD_WIDTH = 8
);
  logic                  cfg_en;
  logic [WORD_WIDTH-1:0] cfg_in_data;
  logic                  cfg_in_valid;
  logic                  cfg_in_ready;
`ifdef CFG_PARITY_EN
  logic                  cfg_in_parity;
`endif
  logic [WORD_WIDTH-1:0] cfg_out_data;
  logic                  cfg_out_valid;
  logic                  cfg_out_ready;
  logic [CFG_SIZE-1:0]   cfg;
  logic                  cfg_done;
  logic                  cfg_err;

  modport slave (
`ifdef CFG_PARITY_EN
    input  cfg_in_parity,
`endif
    input  cfg_en, cfg_in_data, cfg_in_valid, cfg_out_ready,
    output cfg_in_ready, cfg_out_data, cfg_out_valid, cfg, cfg_done, cfg_err
  );

  modport master (
`ifdef CFG_PARITY_EN
    output cfg_in_parity,
`endif
    output cfg_en, cfg_in_data, cfg_in_valid, cfg_out_ready,
    input  cfg_in_ready, cfg_out_data, cfg_out_valid, cfg, cfg_done, cfg_err
  );
endinterface

// File: rtl/cfg_loader.sv
// Per-tile config loader: word-serial shift chain, daisy-chain overflow, atomic commit to cfg.
// Define CFG_PARITY_EN to add even-parity checking of incoming words.
module cfg_loader #(
  parameter int CFG_SIZE   = 256,
  parameter int WORD_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  cfg_loader_if.slave  bus
);
  localparam int NUM_WORDS = (CFG_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CHAIN_W   = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                r_state, w_next;
  logic [CHAIN_W-1:0]    r_chain;
  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [CFG_SIZE-1:0]   r_cfg;
  logic                  r_done;
  logic                  r_err;

  logic w_in_ready, w_accept, w_full, w_exit, w_enter, w_commit, w_commit_ok, w_par_blk;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cfg_en) w_next = LOAD;
      LOAD:    if (!bus.cfg_en) w_next = COMMIT;
      COMMIT:  w_next = bus.cfg_en ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Input stalls only while a forwarded word is stuck downstream.
  assign w_in_ready  = (r_state == LOAD) && (!r_out_valid || bus.cfg_out_ready);
  assign w_accept    = bus.cfg_in_valid && w_in_ready;
  assign w_full      = (r_cnt == CNT_FULL);
  assign w_exit      = w_accept && w_full;
  assign w_enter     = (w_next == LOAD) && (r_state != LOAD);
  assign w_commit    = (r_state == COMMIT);
  assign w_commit_ok = w_full && !w_par_blk;

`ifdef CFG_PARITY_EN
  logic r_par_err;
  always_ff @(posedge clk) begin
    if (rst)                                                  r_par_err <= 1'b0;
    else if (w_enter)                                         r_par_err <= 1'b0;
    else if (w_accept && ^{bus.cfg_in_data, bus.cfg_in_parity}) r_par_err <= 1'b1;
  end
  assign w_par_blk = r_par_err;
`else
  assign w_par_blk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_chain <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_chain <= {bus.cfg_in_data, r_chain[CHAIN_W-1:WORD_WIDTH]};
      if (w_enter)                 r_cnt <= '0;
      else if (w_accept && !w_full) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Forwarded word persists across state changes until the next tile takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_exit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_chain[WORD_WIDTH-1:0];
    end else if (bus.cfg_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A failed commit in a COMMIT cycle that re-enters LOAD keeps cfg_err visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_commit && w_commit_ok;
      if (w_commit && w_commit_ok) r_cfg <= r_chain[CFG_SIZE-1:0];
      if (w_enter)                  r_err <= 1'b0;
      if (w_commit && !w_commit_ok) r_err <= 1'b1;
    end
  end

  assign bus.cfg_in_ready  = w_in_ready;
  assign bus.cfg_out_data  = r_out_data;
  assign bus.cfg_out_valid = r_out_valid;
  assign bus.cfg           = r_cfg;
  assign bus.cfg_done      = r_done;
  assign bus.cfg_err       = r_err;
endmodule
